tt_sweep_3in: RTL and testbench

TT_SWEEP_3IN -- requirements
Module: tt_sweep_3in

---
 rtl/tt_sweep_pkg.sv | 17 +
 rtl/tt_sweep_3in_if.sv | 20 ++
 rtl/tt_sync.sv | 23 ++
 rtl/tt_sweep_3in.sv | 115 +++++++++++
 tb/tb_tt_sweep_3in.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the 3-input truth-table sweeper.
// Optional expected-word compare is enabled with TT_SWEEP_EXPECT_EN.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    typedef logic [2:0] row_t;

    localparam int   TT_ROWS  = 8;
    localparam row_t ROW_LAST = 3'(TT_ROWS - 1);

endpackage

// File: rtl/tt_sweep_3in_if.sv
// Truth-table word handshake: the sweeper is master, the consumer is slave.
interface tt_sweep_3in_if;

    logic       tt_valid;
    logic       tt_ready;
    logic [7:0] tt_word;

    modport master (
        output tt_valid,
        output tt_word,
        input  tt_ready
    );

    modport slave (
        input  tt_valid,
        input  tt_word,
        output tt_ready
    );

endinterface

// File: rtl/tt_sync.sv
// Multi-flop synchronizer for the asynchronous circuit-under-test output.
module tt_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tt_sweep_3in.sv
// Sweeps all 8 input rows of a 3-input circuit and captures its truth table.
// Define TT_SWEEP_EXPECT_EN to add expect_word and the mismatch flag.
module tt_sweep_3in
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 in1,
    output logic                 in2,
    output logic                 in3,
    input  logic                 dut_out,
    output logic                 busy,
    tt_sweep_3in_if.master       tt
`ifdef TT_SWEEP_EXPECT_EN
    ,input  logic [7:0]          expect_word
    ,output logic                mismatch
`endif
);

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q;
    row_t       row_q;
    row_t       in_q;
    logic [7:0] cnt_q;
    logic [7:0] word_q;
    logic       busy_q;
    logic       valid_q;
    logic       samp;

    tt_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dut_out),
        .q_o   (samp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            in_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (abort) begin
            // word_q is deliberately kept so a partial capture stays visible
            state_q <= S_IDLE;
            row_q   <= '0;
            in_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_SETTLE;
                        row_q   <= '0;
                        in_q    <= '0;
                        cnt_q   <= CNT_LOAD;
                        word_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    // row 0 lands in the MSB so the word reads like a table
                    word_q[~row_q] <= samp;
                    if (row_q == ROW_LAST) begin
                        state_q <= S_DONE;
                        in_q    <= '0;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= S_SETTLE;
                        row_q   <= row_q + 3'd1;
                        in_q    <= row_q + 3'd1;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                S_DONE: begin
                    if (tt.tt_ready) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign {in1, in2, in3} = in_q;
    assign busy            = busy_q;
    assign tt.tt_valid     = valid_q;
    assign tt.tt_word      = word_q;

`ifdef TT_SWEEP_EXPECT_EN
    assign mismatch = valid_q & (word_q != expect_word);
`endif

endmodule

// File: tb/tb_tt_sweep_3in.sv
// Directed bench for tt_sweep_3in: table of circuits plus corner sequences.
// Build with TT_SWEEP_EXPECT_EN defined to also exercise the mismatch flag.
module tb_tt_sweep_3in;

    localparam int SETTLE  = 4;
    localparam int ROW_CYC = SETTLE + 1;
    localparam int LAT     = 40;
    localparam int NV      = 7;

    typedef struct {
        logic [7:0] circ;
        logic [7:0] exp_word;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       in1, in2, in3;
    logic       dut_out;
    logic       busy;
    logic [7:0] circ;
    int         checks;
    int         failures;
    int         vcount;
    int         vbase;
    int         k;
    vec_t       vec [NV];
`ifdef TT_SWEEP_EXPECT_EN
    logic [7:0] expect_word;
    logic       mismatch;
`endif

    tt_sweep_3in_if tt ();

    tt_sweep_3in #(
        .SETTLE_CYCLES (SETTLE),
        .SYNC_STAGES   (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .dut_out (dut_out),
        .busy    (busy),
        .tt      (tt)
`ifdef TT_SWEEP_EXPECT_EN
        ,.expect_word (expect_word)
        ,.mismatch    (mismatch)
`endif
    );

    // circuit under evaluation: row r drives output bit 7-r of circ
    assign dut_out = circ[~{in1, in2, in3}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial vcount = 0;
    always @(posedge tt.tt_valid) vcount = vcount + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic start_sweep();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (tt.tt_valid !== 1'b1 && n < 200) begin
            if (n % ROW_CYC == 0)
                chk("row_drive", 32'({in1, in2, in3}), 32'(n / ROW_CYC));
            @(posedge clk); #1;
            n = n + 1;
        end
        if (n >= 200) chk("valid_timeout", 32'(tt.tt_valid), 32'd1);
    endtask

    task automatic step(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        circ        = 8'h00;
        tt.tt_ready = 1'b1;
`ifdef TT_SWEEP_EXPECT_EN
        expect_word = 8'h85;
`endif
        vec[0] = '{8'h85, 8'h85};
        vec[1] = '{8'h00, 8'h00};
        vec[2] = '{8'hFF, 8'hFF};
        vec[3] = '{8'h01, 8'h01};
        vec[4] = '{8'h80, 8'h80};
        vec[5] = '{8'hA5, 8'hA5};
        vec[6] = '{8'h3C, 8'h3C};

        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(tt.tt_valid), 0);
        chk("rst_word", 32'(tt.tt_word), 0);
        chk("rst_in", 32'({in1, in2, in3}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            circ        = vec[i].circ;
            tt.tt_ready = 1'b1;
            start_sweep();
            wait_valid(k);
            chk("latency", 32'(k), 32'(LAT));
            chk("word", 32'(tt.tt_word), 32'(vec[i].exp_word));
            chk("busy_done", 32'(busy), 1);
            chk("in_done", 32'({in1, in2, in3}), 0);
            step(1);
            chk("valid_drop", 32'(tt.tt_valid), 0);
            chk("busy_idle", 32'(busy), 0);
        end

        // backpressure: word must hold while the consumer stalls
        circ        = 8'hFF;
        tt.tt_ready = 1'b0;
        start_sweep();
        wait_valid(k);
        chk("bp_latency", 32'(k), 32'(LAT));
        for (int j = 0; j < 10; j++) begin
            step(1);
            chk("bp_valid", 32'(tt.tt_valid), 1);
            chk("bp_word", 32'(tt.tt_word), 32'h FF);
        end
        tt.tt_ready = 1'b1;
        step(1);
        chk("bp_release", 32'(tt.tt_valid), 0);
        chk("bp_idle", 32'(busy), 0);

        // abort during row 3 settle keeps the partial word
        circ  = 8'h85;
        vbase = vcount;
        start_sweep();
        step(16);
        chk("ab_row", 32'({in1, in2, in3}), 3);
        chk("ab_part", 32'(tt.tt_word), 32'h80);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_in", 32'({in1, in2, in3}), 0);
        chk("ab_valid", 32'(tt.tt_valid), 0);
        chk("ab_word", 32'(tt.tt_word), 32'h80);
        step(60);
        chk("ab_novalid", 32'(vcount - vbase), 0);
        start_sweep();
        wait_valid(k);
        chk("ab_re_lat", 32'(k), 32'(LAT));
        chk("ab_re_word", 32'(tt.tt_word), 32'h85);
        step(1);

        // start while busy and at the DONE handshake is ignored
        circ        = 8'h3C;
        tt.tt_ready = 1'b0;
        vbase       = vcount;
        start_sweep();
        k = 0;
        while (tt.tt_valid !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k     = k + 1;
            start = (k == 10 || k == 20);
        end
        start = 1'b0;
        chk("sb_latency", 32'(k), 32'(LAT));
        chk("sb_word", 32'(tt.tt_word), 32'h3C);
        tt.tt_ready = 1'b1;
        start       = 1'b1;
        step(1);
        start = 1'b0;
        chk("sb_valid", 32'(tt.tt_valid), 0);
        chk("sb_busy", 32'(busy), 0);
        step(60);
        chk("sb_busy_late", 32'(busy), 0);
        chk("sb_words", 32'(vcount - vbase), 1);

        // asynchronous reset in the row 2 sample cycle
        circ  = 8'hFF;
        vbase = vcount;
        start_sweep();
        step(14);
        chk("rs_part", 32'(tt.tt_word), 32'hC0);
        chk("rs_busy_pre", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_busy", 32'(busy), 0);
        chk("rs_valid", 32'(tt.tt_valid), 0);
        chk("rs_word", 32'(tt.tt_word), 0);
        chk("rs_in", 32'({in1, in2, in3}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(60);
        chk("rs_novalid", 32'(vcount - vbase), 0);
        chk("rs_idle", 32'(busy), 0);

`ifdef TT_SWEEP_EXPECT_EN
        expect_word = 8'h85;
        chk("mm_idle", 32'(mismatch), 0);
        circ        = 8'h81;
        tt.tt_ready = 1'b0;
        start_sweep();
        wait_valid(k);
        chk("mm_diff", 32'(mismatch), 1);
        tt.tt_ready = 1'b1;
        step(1);
        chk("mm_after", 32'(mismatch), 0);
        circ        = 8'h85;
        tt.tt_ready = 1'b0;
        start_sweep();
        wait_valid(k);
        chk("mm_same", 32'(mismatch), 0);
        tt.tt_ready = 1'b1;
        step(1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
